// File: rtl/hamming16t11d_pkg.sv
// rtl/hamming16t11d_pkg.sv - SECDED (16,11) constants, status type and codeword helpers
package hamming16t11d_pkg;

    localparam int DATA_W = 11;
    localparam int CW_W   = 16;
    localparam int SYN_W  = 4;

    // Codeword positions carrying data, LSB of the data word first
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct packed {
        logic             sec;
        logic             ded;
        logic [SYN_W-1:0] syndrome;
    } dec_status_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

    // XOR of the indices of all set bits equals the per-bit parity-group syndrome
    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) begin
                s = s ^ SYN_W'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming16t11d_syn.sv
// rtl/hamming16t11d_syn.sv - combinational syndrome and overall parity of a codeword
module hamming16t11d_syn
    import hamming16t11d_pkg::*;
(
    input  logic [CW_W-1:0]  hv_i,
    output logic [SYN_W-1:0] syn_o,
    output logic             par_o
);

    assign syn_o = calc_syndrome(hv_i);
    assign par_o = ^hv_i;

endmodule

// File: rtl/hamming16t11d_dec_pipe.sv
// rtl/hamming16t11d_dec_pipe.sv - 2-stage elastic SECDED decoder with counters (optional HAMMING_DEC_ERRLOG_EN error log)
module hamming16t11d_dec_pipe
    import hamming16t11d_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [15:0]          hv_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [10:0]          data_o,
    output logic                 sec_o,
    output logic                 ded_o,
    output logic [3:0]           syndrome_o,
    input  logic                 clear_cnt_i,
    output logic [CNT_WIDTH-1:0] sec_cnt_o,
    output logic [CNT_WIDTH-1:0] ded_cnt_o
`ifdef HAMMING_DEC_ERRLOG_EN
    ,
    output logic                 errlog_valid_o,
    output logic [3:0]           errlog_syndrome_o,
    output logic                 errlog_ded_o,
    output logic [10:0]          errlog_data_o,
    input  logic                 errlog_clear_i
`endif
);

    localparam int N_STAGES = 2;

    if (N_STAGES != 2) begin : g_stage_check
        $fatal(1, "hamming16t11d_dec_pipe is built as a syndrome stage plus a correct stage");
    end

    logic              init_q, init_d;
    logic              s1_valid_q, s1_valid_d;
    logic [CW_W-1:0]   s1_hv_q, s1_hv_d;
    logic [SYN_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    dec_status_t       s2_stat_q, s2_stat_d;
    logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;

    logic [SYN_W-1:0]  syn_w;
    logic              par_w;
    logic              s2_load, s1_advance, out_fire;
    logic [CW_W-1:0]   corrected;
    logic [DATA_W-1:0] dec_data;
    dec_status_t       dec_stat;

    hamming16t11d_syn u_syn (
        .hv_i  (hv_i),
        .syn_o (syn_w),
        .par_o (par_w)
    );

    // Handshake: a stage loads when empty or when its word leaves this cycle; ready held low until the cycle after reset release
    always_comb begin
        s2_load    = !s2_valid_q || ready_i;
        s1_advance = s1_valid_q && s2_load;
        ready_o    = init_q && (!s1_valid_q || s1_advance);
        out_fire   = s2_valid_q && ready_i;
    end

    // Correct stage: classify by overall parity and syndrome, flip the indicated bit on a single error
    always_comb begin
        corrected         = s1_hv_q;
        dec_stat          = '0;
        dec_stat.syndrome = s1_syn_q;
        if (s1_par_q) begin
            dec_stat.sec = 1'b1;
            if (s1_syn_q != '0) begin
                corrected[s1_syn_q] = ~corrected[s1_syn_q];
            end
        end else if (s1_syn_q != '0) begin
            dec_stat.ded = 1'b1;
        end
        dec_data = extract_data(corrected);
    end

    // Next state of both pipeline stages and the saturating event counters
    always_comb begin
        init_d     = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_hv_d    = s1_hv_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_stat_d  = s2_stat_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;

        if (ready_o) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_hv_d  = hv_i;
                s1_syn_d = syn_w;
                s1_par_d = par_w;
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_advance) begin
            s2_data_d = dec_data;
            s2_stat_d = dec_stat;
        end

        if (clear_cnt_i) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_fire) begin
            if (s2_stat_q.sec && !(&sec_cnt_q)) begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
            if (s2_stat_q.ded && !(&ded_cnt_q)) begin
                ded_cnt_d = ded_cnt_q + 1'b1;
            end
        end
    end

    // Pipeline and counter registers; reset discards any in-flight words
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            init_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_hv_q    <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_stat_q  <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            init_q     <= init_d;
            s1_valid_q <= s1_valid_d;
            s1_hv_q    <= s1_hv_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_stat_q  <= s2_stat_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign valid_o    = s2_valid_q;
    assign data_o     = s2_data_q;
    assign sec_o      = s2_stat_q.sec;
    assign ded_o      = s2_stat_q.ded;
    assign syndrome_o = s2_stat_q.syndrome;
    assign sec_cnt_o  = sec_cnt_q;
    assign ded_cnt_o  = ded_cnt_q;

`ifdef HAMMING_DEC_ERRLOG_EN
    logic [DATA_W-1:0] s2_raw_q, s2_raw_d;
    logic              elog_valid_q, elog_valid_d;
    logic [SYN_W-1:0]  elog_syn_q, elog_syn_d;
    logic              elog_ded_q, elog_ded_d;
    logic [DATA_W-1:0] elog_data_q, elog_data_d;

    // Sticky log of the first erroneous output word; clear takes priority over capture
    always_comb begin
        s2_raw_d     = s2_raw_q;
        elog_valid_d = elog_valid_q;
        elog_syn_d   = elog_syn_q;
        elog_ded_d   = elog_ded_q;
        elog_data_d  = elog_data_q;
        if (s1_advance) begin
            s2_raw_d = extract_data(s1_hv_q);
        end
        if (errlog_clear_i) begin
            elog_valid_d = 1'b0;
            elog_syn_d   = '0;
            elog_ded_d   = 1'b0;
            elog_data_d  = '0;
        end else if (!elog_valid_q && out_fire && (s2_stat_q.sec || s2_stat_q.ded)) begin
            elog_valid_d = 1'b1;
            elog_syn_d   = s2_stat_q.syndrome;
            elog_ded_d   = s2_stat_q.ded;
            elog_data_d  = s2_raw_q;
        end
    end

    // Error log registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_raw_q     <= '0;
            elog_valid_q <= 1'b0;
            elog_syn_q   <= '0;
            elog_ded_q   <= 1'b0;
            elog_data_q  <= '0;
        end else begin
            s2_raw_q     <= s2_raw_d;
            elog_valid_q <= elog_valid_d;
            elog_syn_q   <= elog_syn_d;
            elog_ded_q   <= elog_ded_d;
            elog_data_q  <= elog_data_d;
        end
    end

    assign errlog_valid_o    = elog_valid_q;
    assign errlog_syndrome_o = elog_syn_q;
    assign errlog_ded_o      = elog_ded_q;
    assign errlog_data_o     = elog_data_q;
`endif

endmodule

// File: tb/tb_hamming16t11d_dec_pipe.sv
// tb/tb_hamming16t11d_dec_pipe.sv - scoreboard bench for the pipelined SECDED decoder
module tb_hamming16t11d_dec_pipe;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clk, rstn;
    logic          valid_i, ready_o, valid_o, ready_i;
    logic [15:0]   hv_i;
    logic [10:0]   data_o;
    logic          sec_o, ded_o;
    logic [3:0]    syndrome_o;
    logic          clear_cnt_i;
    logic [CW-1:0] sec_cnt_o, ded_cnt_o;
`ifdef HAMMING_DEC_ERRLOG_EN
    logic          errlog_valid_o, errlog_ded_o, errlog_clear_i;
    logic [3:0]    errlog_syndrome_o;
    logic [10:0]   errlog_data_o;
`endif

    typedef struct packed {
        logic [10:0] data;
        logic        sec;
        logic        ded;
        logic [3:0]  syn;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          tests, fails, cycle;
    int          exp_sec, exp_ded;
    logic        rand_ready, stall;
    logic [10:0] held_data;
    logic        held_sec, held_ded;
    logic [3:0]  held_syn;

    hamming16t11d_dec_pipe #(.CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .hv_i        (hv_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .sec_o       (sec_o),
        .ded_o       (ded_o),
        .syndrome_o  (syndrome_o),
        .clear_cnt_i (clear_cnt_i),
        .sec_cnt_o   (sec_cnt_o),
        .ded_cnt_o   (ded_cnt_o)
`ifdef HAMMING_DEC_ERRLOG_EN
        ,
        .errlog_valid_o    (errlog_valid_o),
        .errlog_syndrome_o (errlog_syndrome_o),
        .errlog_ded_o      (errlog_ded_o),
        .errlog_data_o     (errlog_data_o),
        .errlog_clear_i    (errlog_clear_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    // Random downstream backpressure while enabled
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: counter model, stall stability and scoreboard pop on every output handshake
    always @(negedge clk) begin
        if (!rstn) begin
            exp_sec = 0;
            exp_ded = 0;
            stall   = 1'b0;
        end else begin
            check("sec_cnt", 32'(sec_cnt_o), 32'(exp_sec));
            check("ded_cnt", 32'(ded_cnt_o), 32'(exp_ded));
            if (stall) begin
                check("stall_valid", 32'(valid_o), 32'd1);
                check("stall_data", 32'(data_o), 32'(held_data));
                check("stall_flags", 32'({sec_o, ded_o, syndrome_o}), 32'({held_sec, held_ded, held_syn}));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got data %0h, expected no output", data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(data_o), 32'(e.data));
                    check("sec", 32'(sec_o), 32'(e.sec));
                    check("ded", 32'(ded_o), 32'(e.ded));
                    check("syndrome", 32'(syndrome_o), 32'(e.syn));
                    if (!clear_cnt_i) begin
                        if (e.sec && exp_sec < MAXC) exp_sec++;
                        if (e.ded && exp_ded < MAXC) exp_ded++;
                    end
                end
            end
            if (clear_cnt_i) begin
                exp_sec = 0;
                exp_ded = 0;
            end
            stall     = valid_o && !ready_i;
            held_data = data_o;
            held_sec  = sec_o;
            held_ded  = ded_o;
            held_syn  = syndrome_o;
        end
    end

    task automatic send(input logic [15:0] hv, input logic [10:0] d, input logic s,
                        input logic dd, input logic [3:0] syn);
        bit ok;
        exp_q.push_back('{data: d, sec: s, ded: dd, syn: syn});
        valid_i = 1'b1;
        hv_i    = hv;
        ok      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: codeword, data, sec, ded, syndrome
    logic [15:0] dv_hv  [8] = '{16'hFFFF, 16'hFFBF, 16'h0028, 16'h0001, 16'h0000, 16'h8000, 16'hFFFE, 16'h0003};
    logic [10:0] dv_d   [8] = '{11'h7FF, 11'h7FF, 11'h003, 11'h000, 11'h000, 11'h000, 11'h7FF, 11'h000};
    logic        dv_s   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        dv_dd  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  dv_syn [8] = '{4'h0, 4'h6, 4'h6, 4'h0, 4'h0, 4'hF, 4'h0, 4'h1};

    // Stream vectors with backpressure (includes clean codewords for data 001, 400, 002)
    logic [15:0] sv_hv  [8] = '{16'hFFFF, 16'h000F, 16'h8117, 16'h0033, 16'h0000, 16'hFFBF, 16'h0028, 16'h0001};
    logic [10:0] sv_d   [8] = '{11'h7FF, 11'h001, 11'h400, 11'h002, 11'h000, 11'h7FF, 11'h003, 11'h000};
    logic        sv_s   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        sv_dd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  sv_syn [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h6, 4'h0};

    initial begin
        bit ok;
        tests       = 0;
        fails       = 0;
        cycle       = 0;
        rand_ready  = 1'b0;
        rstn        = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b0;
        hv_i        = '0;
        clear_cnt_i = 1'b0;
`ifdef HAMMING_DEC_ERRLOG_EN
        errlog_clear_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_flags", 32'({sec_o, ded_o, syndrome_o}), 32'd0);
        check("rst_cnts", 32'({sec_cnt_o, ded_cnt_o}), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        ready_i = 1'b1;

        // Latency: valid_o low one cycle after the input handshake, high the next
        send(dv_hv[0], dv_d[0], dv_s[0], dv_dd[0], dv_syn[0]);
        @(negedge clk);
        check("latency_c1", 32'(valid_o), 32'd0);
        @(negedge clk);
        check("latency_c2", 32'(valid_o), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 1; i < 8; i++) send(dv_hv[i], dv_d[i], dv_s[i], dv_dd[i], dv_syn[i]);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(sv_hv[i], sv_d[i], sv_s[i], sv_dd[i], sv_syn[i]);
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        ready_i = 1'b1;

        // Saturation: more SEC events than the 4-bit counter can hold
        for (int i = 0; i < 17; i++) send(16'hFFBF, 11'h7FF, 1'b1, 1'b0, 4'h6);
        drain();
        @(negedge clk);
        check("sec_saturated", 32'(sec_cnt_o), 32'hF);
        @(posedge clk);
        #1;

        // Clear in the same cycle as a DED output handshake
        ready_i = 1'b0;
        send(16'h0028, 11'h003, 1'b0, 1'b1, 4'h6);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ded_wait_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ready_i     = 1'b1;
        clear_cnt_i = 1'b1;
        @(posedge clk);
        #1;
        clear_cnt_i = 1'b0;
        @(negedge clk);
        check("ded_cnt_cleared", 32'(ded_cnt_o), 32'd0);
        check("sec_cnt_cleared", 32'(sec_cnt_o), 32'd0);
        @(posedge clk);
        #1;

        send(16'h0003, 11'h000, 1'b0, 1'b1, 4'h1);
        drain();
        @(negedge clk);
        check("ded_cnt_after_clear", 32'(ded_cnt_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hamming16t11d_dec_pipe.md
Name: hamming16t11d_dec_pipe

Overview:
- Pipelined SECDED decoder for 16-bit extended Hamming codewords: 11 data bits, 4 Hamming check bits and 1 overall parity bit.
- Sits at the read side of SEU-protected registers and storage in the safety IP.
- Returns corrected data with a single-error-corrected (SEC) or double-error-detected (DED) flag.
- Keeps saturating SEC/DED event counters that the safety unit reads.

Parameters:
- CNT_WIDTH, 16, width of each saturating error counter.
- N_STAGES is fixed (localparam) at 2: syndrome stage, then correct stage.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  input codeword valid
- ready_o  out  1  decoder can accept a codeword
- hv_i  in  16  codeword. Bit 0 = overall parity; bits 1,2,4,8 = check bits; data at positions 3,5,6,7,9..15 (LSB first).
- valid_o  out  1  output valid
- ready_i  in  1  downstream accepts
- data_o  out  11  decoded data
- sec_o  out  1  single error corrected (qualified by valid_o)
- ded_o  out  1  double error detected (qualified by valid_o)
- syndrome_o  out  4  syndrome of the output word
- clear_cnt_i  in  1  synchronous counter clear
- sec_cnt_o  out  CNT_WIDTH  SEC event count
- ded_cnt_o  out  CNT_WIDTH  DED event count

Behaviour:
- Reset (async assert, sync-safe release):
  - valid_o=0, data_o=0, sec_o=0, ded_o=0, syndrome_o=0, counters=0.
  - ready_o=1 one cycle after reset release.
- Handshakes are valid/ready on both sides. A transfer occurs when valid&&ready are high at a clock edge.
  - Once valid_o is asserted, data_o, sec_o, ded_o and syndrome_o hold stable until accepted.
- Stage 1 registers hv_i, syndrome s and overall parity p.
  - s[k] = XOR of hv_i bits whose index has bit k set (indices 1..15).
  - p = ^hv_i[15:0].
- Stage 2 registers the decode result:
  - s==0, p==0: clean. Data extracted unchanged; sec=0, ded=0.
  - p==1, s!=0: flip hv bit s, extract data; sec=1.
  - p==1, s==0: parity bit 0 in error. Data unchanged; sec=1.
  - p==0, s!=0: ded=1, sec=0. Data extracted uncorrected.
- Latency: 2 cycles from input handshake to valid_o under no backpressure. Throughput is 1 word/cycle.
- Elastic pipeline:
  - A stage loads when it is empty or its contents are leaving that same cycle.
  - ready_o = !s1_valid || s1_advance.
  - No bubbles are inserted while ready_i stays high. No word is lost or duplicated under any ready_i pattern.
- Counters:
  - Increment on output handshake when sec_o (resp. ded_o) is set.
  - Saturate at all-ones, no wrap.
  - clear_cnt_i zeroes both counters and wins over a same-cycle increment; that event is not counted.
- Reset mid-operation discards all in-flight words. No output handshake occurs for them.

Optional Feature:
- Macro: HAMMING_DEC_ERRLOG_EN.
- When defined, adds these ports:
  - errlog_valid_o (1)
  - errlog_syndrome_o (4)
  - errlog_ded_o (1)
  - errlog_data_o (11, raw extracted data)
  - errlog_clear_i (1)
- The log captures the first SEC/DED output handshake after reset or errlog_clear_i, then stays sticky.
  - Later errors do not overwrite it.
  - Clear and capture in the same cycle: clear wins.
  - Reset value is all zeros.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hamming16t11d_pkg holds:
  - constants DATA_W=11, CW_W=16, SYN_W=4;
  - the data-position index list;
  - a typedef for the decode-status struct {sec, ded, syndrome};
  - functions extract_data() and calc_syndrome().
- One natural sub-module, hamming16t11d_syn: purely combinational syndrome/parity calculation, instantiated in stage 1.

Test Plan:
- hv_i=16'hFFFF, ready_i=1 -> 2 cycles later: data_o=11'h7FF, sec_o=0, ded_o=0, syndrome_o=0.
- hv_i=16'hFFBF (bit 6 flipped) -> data_o=11'h7FF, sec_o=1, syndrome_o=6, sec_cnt_o becomes 1.
- hv_i=16'h0028 (bits 3,5 flipped from 16'h0000) -> ded_o=1, sec_o=0, syndrome_o=6, data_o=11'h003, ded_cnt_o becomes 1.
- hv_i=16'h0001 -> data_o=0, sec_o=1, syndrome_o=0.
- Back-to-back stream of 8 words with ready_i toggled pseudo-randomly -> in-order, no loss or duplication, outputs stable while stalled.
- Saturation and clear:
  - Force sec_cnt to all-ones, inject one SEC -> counter stays at all-ones.
  - Pulse clear_cnt_i in the same cycle as a DED handshake -> ded_cnt_o=0.
